// File: rtl/me_pkg.sv
// me_pkg: shared motion-estimation constants and types.
//   REF_WORD_W    - width of one reference word in bits
//   REF_NUM_WORDS - words per reference row bus (power of two)
//   REF_SHIFT_W   - width of a word-rotation amount, log2(REF_NUM_WORDS)
//   ref_word_t    - one reference word
//   ref_bus_t     - one reference row as an array of words
package me_pkg;

   localparam int unsigned REF_WORD_W    = 64;
   localparam int unsigned REF_NUM_WORDS = 32;
   localparam int unsigned REF_SHIFT_W   = 5;

   typedef logic [REF_WORD_W-1:0] ref_word_t;
   typedef ref_word_t ref_bus_t [REF_NUM_WORDS];

endpackage : me_pkg

// File: rtl/ref_word_rotator.sv
// ref_word_rotator: combinational word-granular barrel rotator.
//   data_in  - NUM_WORDS words of WORD_W bits, word k at [WORD_W*k +: WORD_W]
//   amount   - rotation in words
//   data_out - word k = data_in word (k + amount) mod NUM_WORDS
// Each of log2(NUM_WORDS) stages rotates right by 2^i words when amount[i] is set.
module ref_word_rotator
   import me_pkg::*;
#(
   parameter int unsigned WORD_W    = REF_WORD_W,
   parameter int unsigned NUM_WORDS = REF_NUM_WORDS
) (
   input  logic [WORD_W*NUM_WORDS-1:0]   data_in,
   input  logic [$clog2(NUM_WORDS)-1:0]  amount,
   output logic [WORD_W*NUM_WORDS-1:0]   data_out
);

   localparam int unsigned BUS_W = WORD_W * NUM_WORDS;
   localparam int unsigned AMT_W = $clog2(NUM_WORDS);

   logic [BUS_W-1:0] stage [AMT_W+1];

   assign stage[0] = data_in;

   for (genvar i = 0; i < AMT_W; i++) begin : g_stage
      localparam int unsigned STEP_BITS = (2 ** i) * WORD_W;
      // Rotate right by STEP_BITS: the low words drop out and wrap to the top.
      assign stage[i+1] = amount[i]
         ? {stage[i][STEP_BITS-1:0], stage[i][BUS_W-1:STEP_BITS]}
         : stage[i];
   end

   assign data_out = stage[AMT_W];

endmodule : ref_word_rotator

// File: rtl/ref_mem_shift.sv
// ref_mem_shift: registered word rotator for the motion-estimation reference row.
//   clk         - clock, all state on posedge
//   rst_n       - synchronous active-low reset, clears ref_output
//   ref_input   - reference row, word k = ref_input[WORD_W*k +: WORD_W]
//   shift_value - rotation amount in words
//   ref_output  - rotated row, registered (1 cycle latency), loads every cycle
module ref_mem_shift
   import me_pkg::*;
#(
   parameter int unsigned WORD_W    = REF_WORD_W,
   parameter int unsigned NUM_WORDS = REF_NUM_WORDS,
   parameter int unsigned SHIFT_W   = REF_SHIFT_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WORD_W*NUM_WORDS-1:0]   ref_input,
   input  logic [SHIFT_W-1:0]            shift_value,
   output logic [WORD_W*NUM_WORDS-1:0]   ref_output
);

   logic [WORD_W*NUM_WORDS-1:0] rotated;

   ref_word_rotator #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_rotator (
      .data_in  (ref_input),
      .amount   (shift_value),
      .data_out (rotated)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_output <= '0;
      end else begin
         ref_output <= rotated;
      end
   end

endmodule : ref_mem_shift

// File: tb/tb_ref_mem_shift.sv
// tb_ref_mem_shift: directed self-checking bench for ref_mem_shift.
module tb_ref_mem_shift;

   localparam int unsigned W  = 64;
   localparam int unsigned N  = 32;
   localparam int unsigned BW = W * N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [BW-1:0] ref_input;
   logic [4:0]    shift_value;
   logic [BW-1:0] ref_output;

   int unsigned checks = 0;
   int unsigned errors = 0;

   ref_mem_shift #(
      .WORD_W    (W),
      .NUM_WORDS (N),
      .SHIFT_W   (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ref_input   (ref_input),
      .shift_value (shift_value),
      .ref_output  (ref_output)
   );

   always #5 clk = ~clk;

   // Words 31..8 = 1, words 7..0 = 0.
   localparam logic [BW-1:0] PATTERN = {{24{64'h1}}, {8{64'h0}}};

   function automatic logic [BW-1:0] rot_model(input logic [BW-1:0] b, input int unsigned s);
      logic [BW-1:0] r;
      for (int unsigned k = 0; k < N; k++) begin
         r[k*W +: W] = b[((k + s) % N)*W +: W];
      end
      return r;
   endfunction

   // Index of the first differing word, used only to keep FAIL lines short.
   function automatic int unsigned first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
      for (int unsigned k = 0; k < N; k++) begin
         if (a[k*W +: W] !== b[k*W +: W]) return k;
      end
      return 0;
   endfunction

   function automatic logic [BW-1:0] rand_bus();
      logic [BW-1:0] r;
      for (int unsigned k = 0; k < BW/32; k++) begin
         r[k*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      exp_v = '0;
      rst_n = 1'b0;
      ref_input = PATTERN;
      shift_value = 5'd8;
      step();
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL reset word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
      rst_n = 1'b1;
      #2;
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL reset_release_no_edge word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
   endtask

   task automatic test_shift8();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      exp_v = {{8{64'h0}}, {24{64'h1}}};
      ref_input = PATTERN;
      shift_value = 5'd8;
      step();
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL shift8 word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
   endtask

   task automatic test_pass();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      exp_v = PATTERN;
      ref_input = PATTERN;
      shift_value = 5'd0;
      step();
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL shift0 word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
   endtask

   task automatic test_shift16();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      exp_v = {{8{64'h1}}, {8{64'h0}}, {16{64'h1}}};
      ref_input = PATTERN;
      shift_value = 5'd16;
      step();
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL shift16 word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
   endtask

   task automatic test_wrap();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      ref_input = '0;
      ref_input[63:0] = 64'hDEAD_BEEF;
      exp_v = '0;
      exp_v[127:64] = 64'hDEAD_BEEF;
      shift_value = 5'd31;
      step();
      checks++;
      if (ref_output !== exp_v) begin
         errors++;
         d = first_diff(ref_output, exp_v);
         $display("FAIL wrap31 word %0d got %h expected %h", d, ref_output[d*W +: W], exp_v[d*W +: W]);
      end
   endtask

   // New bus and shift every cycle; a reset is dropped in partway through.
   task automatic test_back_to_back();
      logic [BW-1:0] exp_v;
      int unsigned   d;
      for (int unsigned s = 0; s < N; s++) begin
         ref_input = rand_bus();
         shift_value = s[4:0];
         exp_v = rot_model(ref_input, s);
         if (s == 20) begin
            rst_n = 1'b0;
            exp_v = '0;
         end else begin
            rst_n = 1'b1;
         end
         step();
         checks++;
         if (ref_output !== exp_v) begin
            errors++;
            d = first_diff(ref_output, exp_v);
            $display("FAIL sweep shift %0d rst_n %0b word %0d got %h expected %h",
                     s, rst_n, d, ref_output[d*W +: W], exp_v[d*W +: W]);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      ref_input = '0;
      shift_value = '0;
      @(negedge clk);
      test_reset();
      test_shift8();
      test_pass();
      test_shift16();
      test_wrap();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ref_mem_shift
